// File: rtl/uart_rx.sv
// rtl/uart_rx.sv - 8N1 UART receiver on a 16x baud clock with valid/ack handshake
module uart_rx #(
    parameter int DATA_BITS  = 8,
    parameter int OVERSAMPLE = 16
) (
    input  logic                 bclk,
    input  logic                 rst,
    input  logic                 rxd,
    input  logic                 rx_ack,
    output logic [DATA_BITS-1:0] dout,
    output logic                 rx_valid,
    output logic                 frame_err,
    output logic                 overrun,
    output logic                 rx_busy
);

    localparam int CNT_W = $clog2(OVERSAMPLE);
    localparam int IDX_W = (DATA_BITS > 1) ? $clog2(DATA_BITS) : 1;
    localparam logic [CNT_W-1:0] CNT_HALF = CNT_W'(OVERSAMPLE / 2 - 1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(OVERSAMPLE - 1);
    localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(DATA_BITS - 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_START,
        S_DATA,
        S_STOP,
        S_BREAK
    } state_t;

    state_t               state, state_next;
    logic [CNT_W-1:0]     cnt, cnt_next;
    logic [IDX_W-1:0]     idx, idx_next;
    logic [DATA_BITS-1:0] shift, shift_next;
    logic                 rxd_m, rxd_s;
    logic                 load, bad_stop;

    // Both synchronizer flops reset high so reset never looks like a start bit
    always_ff @(posedge bclk or negedge rst) begin
        if (!rst) begin
            rxd_m <= 1'b1;
            rxd_s <= 1'b1;
        end else begin
            rxd_m <= rxd;
            rxd_s <= rxd_m;
        end
    end

    always_ff @(posedge bclk or negedge rst) begin
        if (!rst) begin
            state <= S_IDLE;
            cnt   <= '0;
            idx   <= '0;
            shift <= '0;
        end else begin
            state <= state_next;
            cnt   <= cnt_next;
            idx   <= idx_next;
            shift <= shift_next;
        end
    end

    always_comb begin
        state_next = state;
        cnt_next   = cnt;
        idx_next   = idx;
        shift_next = shift;
        load       = 1'b0;
        bad_stop   = 1'b0;
        unique case (state)
            S_IDLE: begin
                cnt_next = '0;
                if (!rxd_s) state_next = S_START;
            end
            S_START: begin
                if (cnt == CNT_HALF) begin
                    cnt_next   = '0;
                    idx_next   = '0;
                    state_next = rxd_s ? S_IDLE : S_DATA;
                end else begin
                    cnt_next = cnt + CNT_W'(1);
                end
            end
            S_DATA: begin
                if (cnt == CNT_LAST) begin
                    cnt_next   = '0;
                    shift_next = {rxd_s, shift[DATA_BITS-1:1]};
                    idx_next   = idx + IDX_W'(1);
                    if (idx == IDX_LAST) state_next = S_STOP;
                end else begin
                    cnt_next = cnt + CNT_W'(1);
                end
            end
            S_STOP: begin
                if (cnt == CNT_LAST) begin
                    cnt_next = '0;
                    if (rxd_s) begin
                        load       = 1'b1;
                        state_next = S_IDLE;
                    end else begin
                        bad_stop   = 1'b1;
                        state_next = S_BREAK;
                    end
                end else begin
                    cnt_next = cnt + CNT_W'(1);
                end
            end
            S_BREAK: begin
                cnt_next = '0;
                if (rxd_s) state_next = S_IDLE;
            end
            default: state_next = S_IDLE;
        endcase
    end

    // A byte landing on the ack edge wins: it stays valid and is not an overrun
    always_ff @(posedge bclk or negedge rst) begin
        if (!rst) begin
            dout      <= '0;
            rx_valid  <= 1'b0;
            frame_err <= 1'b0;
            overrun   <= 1'b0;
        end else begin
            frame_err <= bad_stop;
            if (load) begin
                dout     <= shift;
                rx_valid <= 1'b1;
                overrun  <= rx_valid && !rx_ack;
            end else if (rx_ack && rx_valid) begin
                rx_valid <= 1'b0;
                overrun  <= 1'b0;
            end
        end
    end

    assign rx_busy = (state != S_IDLE);

endmodule

// File: tb/tb_uart_rx.sv
// tb/tb_uart_rx.sv - scoreboard bench for uart_rx with directed frames
module tb_uart_rx;

    logic       bclk = 1'b0;
    logic       rst;
    logic       rxd;
    logic       rx_ack;
    logic [7:0] dout;
    logic       rx_valid;
    logic       frame_err;
    logic       overrun;
    logic       rx_busy;

    uart_rx #(.DATA_BITS(8), .OVERSAMPLE(16)) dut (
        .bclk      (bclk),
        .rst       (rst),
        .rxd       (rxd),
        .rx_ack    (rx_ack),
        .dout      (dout),
        .rx_valid  (rx_valid),
        .frame_err (frame_err),
        .overrun   (overrun),
        .rx_busy   (rx_busy)
    );

    always #5 bclk = ~bclk;

    int cyc = 0;
    always @(posedge bclk) cyc <= cyc + 1;

    typedef struct {
        logic [7:0] data;
        logic       ovr;
        int         at;
    } exp_t;

    exp_t exp_q[$];
    int   fe_q[$];
    int   checks = 0;
    int   errors = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, req, cyc);
        end
    endtask

    task automatic wait_cyc(input int t);
        for (int i = 0; i < 100000 && cyc < t; i++) @(negedge bclk);
    endtask

    // Called on a negedge; returns on the negedge ending the stop bit.
    // kind: 0 no expectation, 1 good byte expected, 2 framing error expected
    task automatic send_frame(input logic [7:0] d, input logic stop_bit,
                              input int kind, input logic ovr);
        exp_t e;
        int   k;
        k = cyc + 1;
        if (kind == 1) begin
            e.data = d;
            e.ovr  = ovr;
            e.at   = k + 154;
            exp_q.push_back(e);
        end else if (kind == 2) begin
            fe_q.push_back(k + 154);
        end
        rxd = 1'b0;
        repeat (16) @(negedge bclk);
        for (int i = 0; i < 8; i++) begin
            rxd = d[i];
            repeat (16) @(negedge bclk);
        end
        rxd = stop_bit;
        repeat (16) @(negedge bclk);
    endtask

    task automatic ack_pulse();
        rx_ack = 1'b1;
        @(negedge bclk);
        rx_ack = 1'b0;
    endtask

    // Monitor: a newly presented byte is a rising rx_valid or a changed dout
    logic       prev_valid = 1'b0;
    logic [7:0] prev_dout  = 8'h00;
    always @(negedge bclk) begin
        exp_t e;
        int   t;
        if (rst === 1'b1) begin
            if (rx_valid && (!prev_valid || dout != prev_dout)) begin
                if (exp_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_byte: got %0h expected none (cycle %0d)", dout, cyc);
                end else begin
                    e = exp_q.pop_front();
                    chk("byte_dout", {24'd0, dout}, {24'd0, e.data});
                    chk("byte_overrun", {31'd0, overrun}, {31'd0, e.ovr});
                    chk("byte_cycle", cyc, e.at);
                    chk("byte_frame_err", {31'd0, frame_err}, 32'd0);
                end
            end
            if (frame_err) begin
                if (fe_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_frame_err: got 1 expected 0 (cycle %0d)", cyc);
                end else begin
                    t = fe_q.pop_front();
                    chk("frame_err_cycle", cyc, t);
                    chk("frame_err_no_valid", {31'd0, rx_valid}, 32'd0);
                end
            end
        end
        prev_valid = rx_valid;
        prev_dout  = dout;
    end

    initial begin
        int k;
        rst    = 1'b0;
        rxd    = 1'b1;
        rx_ack = 1'b0;
        repeat (3) @(negedge bclk);
        chk("reset_outputs", {dout, rx_valid, frame_err, overrun, rx_busy}, 32'd0);
        rst = 1'b1;
        repeat (5) @(negedge bclk);

        // 0x65 with timing and busy checks
        k = cyc + 1;
        fork
            send_frame(8'h65, 1'b1, 1, 1'b0);
            begin
                wait_cyc(k + 80);
                chk("busy_mid_frame", {31'd0, rx_busy}, 32'd1);
                wait_cyc(k + 155);
                chk("busy_after_frame", {31'd0, rx_busy}, 32'd0);
            end
        join
        chk("valid_0x65", {31'd0, rx_valid}, 32'd1);
        ack_pulse();
        chk("ack_clears_valid", {31'd0, rx_valid}, 32'd0);
        repeat (10) @(negedge bclk);

        // 4-cycle glitch: start rejected, nothing changes
        k = cyc + 1;
        rxd = 1'b0;
        repeat (4) @(negedge bclk);
        rxd = 1'b1;
        wait_cyc(k + 5);
        chk("glitch_busy", {31'd0, rx_busy}, 32'd1);
        wait_cyc(k + 12);
        chk("glitch_idle", {31'd0, rx_busy}, 32'd0);
        chk("glitch_dout", {24'd0, dout}, 32'h65);
        chk("glitch_valid", {31'd0, rx_valid}, 32'd0);
        repeat (30) @(negedge bclk);

        // Bad stop bit, long break, then a clean frame
        send_frame(8'hA3, 1'b0, 2, 1'b0);
        repeat (20) @(negedge bclk);
        chk("break_busy", {31'd0, rx_busy}, 32'd1);
        repeat (20) @(negedge bclk);
        rxd = 1'b1;
        repeat (20) @(negedge bclk);
        send_frame(8'h5A, 1'b1, 1, 1'b0);
        repeat (5) @(negedge bclk);
        ack_pulse();
        repeat (5) @(negedge bclk);

        // Back-to-back frames without ack produce an overrun
        send_frame(8'h11, 1'b1, 1, 1'b0);
        send_frame(8'h22, 1'b1, 1, 1'b1);
        chk("ovr_valid", {31'd0, rx_valid}, 32'd1);
        chk("ovr_flag", {31'd0, overrun}, 32'd1);
        ack_pulse();
        chk("ovr_ack_valid", {31'd0, rx_valid}, 32'd0);
        chk("ovr_ack_flag", {31'd0, overrun}, 32'd0);
        repeat (5) @(negedge bclk);

        // Ack lands on the edge the second frame completes
        k = cyc + 1;
        fork
            begin
                send_frame(8'h3C, 1'b1, 1, 1'b0);
                send_frame(8'hC3, 1'b1, 1, 1'b0);
            end
            begin
                wait_cyc(k + 160 + 153);
                ack_pulse();
            end
        join
        chk("race_valid", {31'd0, rx_valid}, 32'd1);
        chk("race_overrun", {31'd0, overrun}, 32'd0);
        chk("race_dout", {24'd0, dout}, 32'hC3);
        repeat (5) @(negedge bclk);

        // Reset during data bit 4, then a clean 0xFF
        k = cyc + 1;
        fork
            send_frame(8'hF5, 1'b1, 0, 1'b0);
            begin
                wait_cyc(k + 88);
                rst = 1'b0;
                #1;
                chk("midframe_reset_outputs", {dout, rx_valid, frame_err, overrun, rx_busy}, 32'd0);
                repeat (3) @(negedge bclk);
                chk("reset_hold_outputs", {dout, rx_valid, frame_err, overrun, rx_busy}, 32'd0);
                rst = 1'b1;
            end
        join
        repeat (20) @(negedge bclk);
        chk("post_reset_idle", {31'd0, rx_busy}, 32'd0);
        send_frame(8'hFF, 1'b1, 1, 1'b0);
        repeat (10) @(negedge bclk);
        chk("final_valid", {31'd0, rx_valid}, 32'd1);

        chk("byte_queue_drained", exp_q.size(), 32'd0);
        chk("frame_err_queue_drained", fe_q.size(), 32'd0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
